life_grid_engine: RTL

//  Consumer end of the seed interface: accepts the 64-bit seed (8x8 Game-of-Life grid)

---
 rtl/life_pkg.sv | 17 +
 rtl/life_next_gen.sv | 46 ++++
 rtl/life_grid_engine.sv | 77 +++++++
 3 files changed

// File: rtl/life_pkg.sv
// Shared types and grid geometry for the Game-of-Life engine.
package life_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PAUSE = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam int unsigned GRID_N    = 8;
    localparam int unsigned GRID_BITS = GRID_N * GRID_N;

    function automatic logic [5:0] idx(input int unsigned r, input int unsigned c);
        return 6'(r * GRID_N + c);
    endfunction

endpackage

// File: rtl/life_next_gen.sv
// Combinational next-generation evaluator: neighbour count plus B3/S23 rule.
module life_next_gen
    import life_pkg::*;
#(
    parameter int WRAP = 1
) (
    input  logic [63:0] grid,
    output logic [63:0] next_grid
);

    // Offsets are biased by +1 so the loop stays unsigned; rows/cols 1..8 map to 0..7.
    function automatic logic [3:0] neighbours(input logic [63:0] g,
                                              input int unsigned r,
                                              input int unsigned c);
        logic [3:0]  n;
        int unsigned rr;
        int unsigned cc;
        n = '0;
        for (int unsigned dr = 0; dr < 3; dr++) begin
            for (int unsigned dc = 0; dc < 3; dc++) begin
                if (!(dr == 1 && dc == 1)) begin
                    rr = r + dr;
                    cc = c + dc;
                    if (WRAP != 0)
                        n = n + 4'(g[idx((rr + GRID_N - 1) % GRID_N, (cc + GRID_N - 1) % GRID_N)]);
                    else if (rr >= 1 && rr <= GRID_N && cc >= 1 && cc <= GRID_N)
                        n = n + 4'(g[idx(rr - 1, cc - 1)]);
                end
            end
        end
        return n;
    endfunction

    always_comb begin
        logic [3:0] n;
        next_grid = '0;
        n         = '0;
        for (int unsigned r = 0; r < GRID_N; r++) begin
            for (int unsigned c = 0; c < GRID_N; c++) begin
                n = neighbours(grid, r, c);
                next_grid[idx(r, c)] = (n == 4'd3) | (grid[idx(r, c)] & (n == 4'd2));
            end
        end
    end

endmodule

// File: rtl/life_grid_engine.sv
// Holds a seeded 8x8 Life grid and advances it one generation per tick while running.
module life_grid_engine
    import life_pkg::*;
#(
    parameter int GEN_W          = 16,
    parameter int WRAP           = 1,
    parameter int STOP_ON_STABLE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             seed_valid,
    input  logic [63:0]      seed,
    output logic             seed_ready,
    input  logic             run,
    input  logic             step_tick,
    output logic [63:0]      grid,
    output logic [GEN_W-1:0] gen_count,
    output logic             stable,
    output logic             extinct,
    output logic             running
);

    state_t      state_q, state_d;
    logic [63:0] next_grid;
    logic        load;
    logic        do_step;
    logic        same;

    life_next_gen #(.WRAP(WRAP)) u_next_gen (
        .grid      (grid),
        .next_grid (next_grid)
    );

    assign seed_ready = (state_q != RUN);
    assign running    = (state_q == RUN);
    assign load       = seed_valid & seed_ready;
    assign do_step    = (state_q == RUN) & run & step_tick;
    assign same       = (next_grid == grid);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load) state_d = PAUSE;
            PAUSE:   if (load) state_d = PAUSE;
                     else if (run) state_d = RUN;
            RUN:     if (!run) state_d = PAUSE;
                     else if (step_tick && STOP_ON_STABLE != 0 && same) state_d = PAUSE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grid      <= '0;
            gen_count <= '0;
            stable    <= 1'b0;
            extinct   <= 1'b0;
        end else if (load) begin
            grid      <= seed;
            gen_count <= '0;
            stable    <= 1'b0;
            extinct   <= (seed == '0);
        end else if (do_step) begin
            grid      <= next_grid;
            if (gen_count != '1)
                gen_count <= gen_count + GEN_W'(1);
            stable    <= same;
            extinct   <= (next_grid == '0);
        end
    end

endmodule
